// File: rtl/scr1_tcm_dmem_arbiter.sv
// SCR1 TCM data-memory arbiter: N requesters onto one pipelined TCM port.
// Fixed priority with starvation escape, or round-robin; local range errors.
package scr1_memif_pkg;
   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE  = 2'b00,
      SCR1_MEM_WIDTH_HWORD = 2'b01,
      SCR1_MEM_WIDTH_WORD  = 2'b10,
      SCR1_MEM_WIDTH_ERROR = 2'b11
   } type_scr1_mem_width_e;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;
endpackage

module scr1_tcm_dmem_arbiter
   import scr1_memif_pkg::*;
#(
   parameter int          N_PORTS  = 2,
   parameter int          ARB_MODE = 0,
   parameter int          MAX_WAIT = 15,
   parameter logic [31:0] TCM_SIZE = 32'h00010000,
   parameter int          DWIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_PORTS-1:0]   m_req,
   input  type_scr1_mem_cmd_e   m_cmd     [N_PORTS],
   input  type_scr1_mem_width_e m_width   [N_PORTS],
   input  logic [31:0]          m_addr    [N_PORTS],
   input  logic [DWIDTH-1:0]    m_wdata   [N_PORTS],
   output logic [N_PORTS-1:0]   m_req_ack,
   output logic [DWIDTH-1:0]    m_rdata   [N_PORTS],
   output type_scr1_mem_resp_e  m_resp    [N_PORTS],
   output logic                 mem_req,
   output type_scr1_mem_cmd_e   mem_cmd,
   output type_scr1_mem_width_e mem_width,
   output logic [31:0]          mem_addr,
   output logic [DWIDTH-1:0]    mem_wdata,
   input  logic                 mem_req_ack,
   input  logic [DWIDTH-1:0]    mem_rdata,
   input  type_scr1_mem_resp_e  mem_resp
);

   localparam int IW = $clog2(N_PORTS);
   localparam logic [0:0] ADDR = 1'b0;
   localparam logic [0:0] DATA = 1'b1;

   logic [0:0]         state;
   logic [IW-1:0]      owner;
   logic [IW-1:0]      rr_ptr;
   logic               local_err;
   logic [7:0]         wcnt [N_PORTS];

   logic               gnt_vld;
   logic [IW-1:0]      gnt_idx;
   logic [N_PORTS-1:0] rot;
   logic [IW:0]        sum;
   logic               in_range;
   logic               resp_done;
   logic               accept_ok;
   logic               accept;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      rot     = '0;
      sum     = '0;
      if (ARB_MODE == 0) begin
         for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (m_req[i]) begin
               gnt_vld = 1'b1;
               gnt_idx = IW'(i);
            end
         end
         // starving ports override plain priority, lowest index first
         for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (m_req[i] && wcnt[i] >= 8'(MAX_WAIT)) begin
               gnt_idx = IW'(i);
            end
         end
      end else begin
         rot = N_PORTS'({m_req, m_req} >> rr_ptr);
         for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (rot[i]) begin
               gnt_vld = 1'b1;
               sum = {1'b0, rr_ptr} + (IW+1)'(i);
               if (sum >= (IW+1)'(N_PORTS)) begin
                  sum = sum - (IW+1)'(N_PORTS);
               end
               gnt_idx = sum[IW-1:0];
            end
         end
      end
   end

   assign in_range  = m_addr[gnt_idx] < TCM_SIZE;
   assign resp_done = (state == DATA)
                    & (local_err
                    | (mem_resp == SCR1_MEM_RESP_RDY_OK)
                    | (mem_resp == SCR1_MEM_RESP_RDY_ER));
   assign accept_ok = (state == ADDR) | resp_done;
   assign mem_req   = rst_n & gnt_vld & accept_ok & in_range;
   assign accept    = rst_n & gnt_vld & accept_ok
                    & (mem_req_ack | ~in_range);

   assign mem_cmd   = m_cmd[gnt_idx];
   assign mem_width = m_width[gnt_idx];
   assign mem_addr  = m_addr[gnt_idx];
   assign mem_wdata = m_wdata[gnt_idx];

   always_comb begin
      for (int i = 0; i < N_PORTS; i++) begin
         m_req_ack[i] = accept & (gnt_idx == IW'(i));
         m_resp[i]    = SCR1_MEM_RESP_NOTRDY;
         m_rdata[i]   = '0;
         if (state == DATA && owner == IW'(i)) begin
            if (local_err) begin
               m_resp[i] = SCR1_MEM_RESP_RDY_ER;
            end else begin
               m_resp[i]  = mem_resp;
               m_rdata[i] = mem_rdata;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ADDR;
         owner     <= '0;
         rr_ptr    <= '0;
         local_err <= 1'b0;
      end else if (accept) begin
         state     <= DATA;
         owner     <= gnt_idx;
         local_err <= ~in_range;
         rr_ptr    <= (gnt_idx == IW'(N_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (resp_done) begin
         state     <= ADDR;
         local_err <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_PORTS; i++) wcnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_PORTS; i++) begin
            if (!m_req[i] || m_req_ack[i]) begin
               wcnt[i] <= '0;
            end else if (wcnt[i] < 8'(MAX_WAIT)) begin
               wcnt[i] <= wcnt[i] + 8'd1;
            end
         end
      end
   end

endmodule
